// File: rtl/weight_load_ctrl.sv
// Load/drain sequencer for the per-column weight shifter bank feeding the systolic array.
// Optional stall counter is enabled by defining WEIGHT_CTRL_STALL_CNT_EN.
module weight_load_ctrl #(
    parameter int ARRAYWIDTH = 4,
    parameter int DATASIZE   = 8,
    parameter int CNTW       = (ARRAYWIDTH > 1) ? $clog2(ARRAYWIDTH) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           abort,
    input  logic                           w_valid,
    output logic                           w_ready,
    input  logic [ARRAYWIDTH*DATASIZE-1:0] w_data,
    input  logic                           drain_req,
    output logic                           buf_load_en,
    output logic                           buf_out_en,
    output logic [ARRAYWIDTH*DATASIZE-1:0] buf_in_weight,
    output logic                           busy,
    output logic                           weights_loaded,
    output logic                           done,
    output logic [15:0]                    stall_cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FULL,
        S_DRAIN,
        S_DONE
    } state_e;

    localparam logic [CNTW-1:0] LAST_IDX = CNTW'(ARRAYWIDTH - 1);

    state_e            state_q, state_d;
    logic [CNTW-1:0]   row_cnt_q, row_cnt_d;
    logic [CNTW-1:0]   out_cnt_q, out_cnt_d;

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        out_cnt_d = out_cnt_q;
        if (abort) begin
            state_d   = S_IDLE;
            row_cnt_d = '0;
            out_cnt_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d   = S_LOAD;
                        row_cnt_d = '0;
                    end
                end
                S_LOAD: begin
                    if (w_valid) begin
                        if (row_cnt_q == LAST_IDX) begin
                            state_d   = S_FULL;
                            row_cnt_d = '0;
                        end else begin
                            row_cnt_d = row_cnt_q + CNTW'(1);
                        end
                    end
                end
                S_FULL: begin
                    if (drain_req) begin
                        state_d   = S_DRAIN;
                        out_cnt_d = '0;
                    end
                end
                S_DRAIN: begin
                    if (out_cnt_q == LAST_IDX) begin
                        state_d   = S_DONE;
                        out_cnt_d = '0;
                    end else begin
                        out_cnt_d = out_cnt_q + CNTW'(1);
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            row_cnt_q <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    // Strobes decode the current state only, so an abort cycle still shows them.
    assign w_ready        = (state_q == S_LOAD);
    assign buf_load_en    = (state_q == S_LOAD) && w_valid;
    assign buf_out_en     = (state_q == S_DRAIN);
    assign buf_in_weight  = w_data;
    assign busy           = (state_q != S_IDLE);
    assign weights_loaded = (state_q == S_FULL);
    assign done           = (state_q == S_DONE);

`ifdef WEIGHT_CTRL_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if ((state_q == S_IDLE) && start && !abort) begin
            stall_d = '0;
        end else if ((((state_q == S_LOAD) && !w_valid) ||
                      ((state_q == S_FULL) && !drain_req)) &&
                     (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 16'h0;
`endif

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Self-checking bench for weight_load_ctrl: load-data scoreboard plus cycle-exact strobe checks.
module tb_weight_load_ctrl;

    localparam int AW = 4;
    localparam int DS = 8;
    localparam int W  = AW * DS;
`ifdef WEIGHT_CTRL_STALL_CNT_EN
    localparam bit STALL_ON = 1'b1;
`else
    localparam bit STALL_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          w_valid = 1'b0;
    logic          drain_req = 1'b0;
    logic [W-1:0]  w_data = '0;
    logic          w_ready;
    logic          buf_load_en;
    logic          buf_out_en;
    logic [W-1:0]  buf_in_weight;
    logic          busy;
    logic          weights_loaded;
    logic          done;
    logic [15:0]   stall_cycles;

    weight_load_ctrl #(.ARRAYWIDTH(AW), .DATASIZE(DS)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .w_valid        (w_valid),
        .w_ready        (w_ready),
        .w_data         (w_data),
        .drain_req      (drain_req),
        .buf_load_en    (buf_load_en),
        .buf_out_en     (buf_out_en),
        .buf_in_weight  (buf_in_weight),
        .busy           (busy),
        .weights_loaded (weights_loaded),
        .done           (done),
        .stall_cycles   (stall_cycles)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    int load_seen = 0;
    int out_seen = 0;
    int done_seen = 0;
    int lb, ob, db;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] rows[AW];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] stall_exp(input int v);
        return STALL_ON ? 16'(v) : 16'h0;
    endfunction

    // Samples outputs at the falling edge, then advances to just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        if (buf_load_en === 1'b1) begin
            load_seen++;
            if (exp_q.size() == 0) check("load_unexpected", 64'd1, 64'd0);
            else check("load_data", 64'(buf_in_weight), 64'(exp_q.pop_front()));
        end
        if (buf_out_en === 1'b1) out_seen++;
        if (done === 1'b1) done_seen++;
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        lb = load_seen;
        ob = out_seen;
        db = done_seen;
    endtask

    initial begin
        rows[0] = 32'h04030201;
        rows[1] = 32'h08070605;
        rows[2] = 32'h0c0b0a09;
        rows[3] = 32'h100f0e0d;

        // Reset state; w_valid high must not leak into buf_load_en.
        repeat (3) @(posedge clk);
        #1;
        w_valid = 1'b1;
        #2;
        check("rst_busy", busy, 0);
        check("rst_w_ready", w_ready, 0);
        check("rst_load_en", buf_load_en, 0);
        check("rst_out_en", buf_out_en, 0);
        check("rst_loaded", weights_loaded, 0);
        check("rst_done", done, 0);
        check("rst_stall", stall_cycles, 0);
        rst = 1'b0;
        w_valid = 1'b0;
        tick();

        // T1: back-to-back tile, full cycle timing.
        snap();
        start = 1'b1;
        w_valid = 1'b1;
        drain_req = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (c <= AW) begin
                w_data = rows[c-1];
                exp_q.push_back(rows[c-1]);
            end
            #2;
            check("t1_load_en", buf_load_en, (c <= AW));
            check("t1_full", weights_loaded, (c == AW + 1));
            check("t1_out_en", buf_out_en, (c >= AW + 2) && (c <= 2 * AW + 1));
            check("t1_done", done, (c == 2 * AW + 2));
            check("t1_busy", busy, (c <= 2 * AW + 2));
            check("t1_passthru", buf_in_weight, w_data);
            tick();
        end
        w_valid = 1'b0;
        drain_req = 1'b0;
        check("t1_loads", load_seen - lb, AW);
        check("t1_outs", out_seen - ob, AW);
        check("t1_dones", done_seen - db, 1);
        check("t1_stall", stall_cycles, stall_exp(0));

        // T2: gapped w_valid, then a long FULL wait.
        snap();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1, k = 0; c <= 7; c++) begin
            w_valid = (c % 2 == 1);
            if (w_valid) begin
                w_data = rows[k];
                exp_q.push_back(rows[k]);
                k++;
            end
            #2;
            check("t2_w_ready", w_ready, 1);
            tick();
        end
        w_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #2;
            check("t2_loaded", weights_loaded, 1);
            check("t2_no_out", buf_out_en, 0);
            tick();
        end
        drain_req = 1'b1;
        repeat (6) tick();
        drain_req = 1'b0;
        #2;
        check("t2_idle", busy, 0);
        check("t2_loads", load_seen - lb, AW);
        check("t2_outs", out_seen - ob, AW);
        check("t2_dones", done_seen - db, 1);
        check("t2_stall", stall_cycles, stall_exp(3 + 20));

        // T3: abort on the second beat, then a full reload with start held high.
        snap();
        start = 1'b1;
        tick();
        start = 1'b0;
        w_valid = 1'b1;
        w_data = rows[0];
        exp_q.push_back(rows[0]);
        tick();
        w_data = rows[1];
        exp_q.push_back(rows[1]);
        abort = 1'b1;
        #2;
        check("t3_abort_w_ready", w_ready, 1);
        check("t3_abort_load_en", buf_load_en, 1);
        tick();
        abort = 1'b0;
        w_valid = 1'b0;
        #2;
        check("t3_after_abort_busy", busy, 0);
        check("t3_after_abort_w_ready", w_ready, 0);
        start = 1'b1;
        tick();
        w_valid = 1'b1;
        for (int b = 0; b < AW; b++) begin
            w_data = rows[b];
            exp_q.push_back(rows[b]);
            #2;
            check("t3_reload_w_ready", w_ready, 1);
            check("t3_reload_not_full", weights_loaded, 0);
            tick();
        end
        w_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #2;
            check("t3_full_start_ignored", weights_loaded, 1);
            tick();
        end
        check("t3_loads", load_seen - lb, 2 + AW);

        // T4: start held through FULL, DRAIN and DONE has no effect.
        snap();
        drain_req = 1'b1;
        tick();
        drain_req = 1'b0;
        repeat (AW) tick();
        #2;
        check("t4_done", done, 1);
        tick();
        start = 1'b0;
        #2;
        check("t4_idle", busy, 0);
        check("t4_outs", out_seen - ob, AW);
        check("t4_dones", done_seen - db, 1);
        check("t4_stall", stall_cycles, stall_exp(2));

        // T5: start and abort together in IDLE.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        #2;
        check("t5_busy", busy, 0);
        check("t5_w_ready", w_ready, 0);

        // T6: rst during DRAIN.
        start = 1'b1;
        w_valid = 1'b1;
        drain_req = 1'b1;
        tick();
        start = 1'b0;
        for (int b = 0; b < AW; b++) begin
            w_data = rows[b];
            exp_q.push_back(rows[b]);
            tick();
        end
        tick();
        #2;
        check("t6_draining", buf_out_en, 1);
        rst = 1'b1;
        tick();
        #2;
        check("t6_busy", busy, 0);
        check("t6_out_en", buf_out_en, 0);
        check("t6_load_en", buf_load_en, 0);
        check("t6_w_ready", w_ready, 0);
        check("t6_loaded", weights_loaded, 0);
        check("t6_done", done, 0);
        check("t6_stall", stall_cycles, 0);
        rst = 1'b0;
        w_valid = 1'b0;
        drain_req = 1'b0;
        tick();

`ifdef WEIGHT_CTRL_STALL_CNT_EN
        // T7: stall counter saturation while parked in FULL.
        start = 1'b1;
        w_valid = 1'b1;
        tick();
        start = 1'b0;
        for (int b = 0; b < AW; b++) begin
            w_data = rows[b];
            exp_q.push_back(rows[b]);
            tick();
        end
        w_valid = 1'b0;
        repeat (66000) tick();
        check("t7_sat", stall_cycles, 16'hFFFF);
        repeat (5) tick();
        check("t7_sat_hold", stall_cycles, 16'hFFFF);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        #2;
        check("t7_idle", busy, 0);
        check("t7_idle_hold", stall_cycles, 16'hFFFF);
`endif

        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
